button_event_scheduler: RTL and testbench
=========================================

Name: button_event_scheduler

Overview:
Front-end controller for the board push-buttons. Synchronizes and debounces NUM_BTNS raw button inputs and converts each debounced 0->1 edge into a one-cycle press event. It queues one pending event per button and schedules them round-robin onto a single valid/ready event channel. The datapath consumes exactly one button command at a time from that channel.

Parameters:
NUM_BTNS, 5, number of button inputs (2..16)
DEBOUNCE_CYCLES, 100000, consecutive stable cycles required to accept a level change (1 ms at 100 MHz); must be >= 2
ID_W, $clog2(NUM_BTNS), width of evt_id (derived localparam, not overridable)

Ports:
clk  in  1  global clock
rst  in  1  reset; synchronous, active-high
btn_in  in  NUM_BTNS  raw asynchronous button levels
evt_valid  out  1  event offered to the consumer
evt_ready  in  1  consumer accepts the event when high with evt_valid
evt_id  out  ID_W  index of the button whose event is offered
btn_level  out  NUM_BTNS  debounced button levels
overrun  out  NUM_BTNS  sticky: a press was lost because the previous one was still pending
clr_overrun  in  1  clears all overrun bits

Behaviour:
- Reset values: evt_valid=0, evt_id=0, btn_level=0, overrun=0, pending=0, synchronizers=0, debounce counters=0, last_grant=NUM_BTNS-1 (button 0 wins first), FSM=IDLE.
- Reset is honoured in any state. A mid-handshake event is discarded and is not re-offered.
- Synchronizer: two flops per bit. A raw change reaches sync_i after 2 clocks.
- Debounce per button:
  - If sync_i == btn_level[i], the counter clears to 0.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 and sync_i still differs, btn_level[i] <= sync_i and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes btn_level.
- Press detect: press[i] is a one-cycle pulse in the cycle after btn_level[i] rises. Falling edges generate nothing.
- Pending/overrun update per cycle, per button i:
  - press[i] && !pending[i] -> pending[i] set.
  - press[i] && pending[i] && !(accept && evt_id==i) -> pending stays set; overrun[i] set.
  - press[i] && accept of i in the same cycle -> pending stays set (new event); no overrun.
  - accept of i without press[i] -> pending[i] cleared.
  - clr_overrun clears all overrun bits. A same-cycle overrun set wins over clr_overrun.
- Scheduler FSM (states IDLE, OFFER):
  - IDLE: if pending != 0, select the first set bit searching last_grant+1, last_grant+2, ... with wrap modulo NUM_BTNS. Register that index into evt_id, set evt_valid=1, go to OFFER. Otherwise stay in IDLE with evt_valid=0.
  - OFFER: evt_valid and evt_id are held stable while evt_ready=0.
  - OFFER with evt_ready=1 (accept): clear pending[evt_id] per the rules above, last_grant <= evt_id, evt_valid <= 0, return to IDLE.
  - Maximum throughput is one event per 2 cycles. Pending bits set while in OFFER do not alter the offered id.
- Latency from a debounced edge: btn_level rises at cycle t, press at t+1, pending at t+2, evt_valid at t+3 (if IDLE).
- evt_id is ID_W bits wide; indices >= NUM_BTNS never appear.

Decomposition:
- Package btn_sched_pkg holds:
  - the FSM state typedef (sched_state_t: IDLE, OFFER);
  - the synchronizer depth constant SYNC_STAGES=2;
  - a function rr_next(pending, last_grant) that returns the round-robin winner.
- One sub-module, button_debouncer: synchronizer, counter and btn_level for a single bit, parameterized by DEBOUNCE_CYCLES. It is instantiated NUM_BTNS times via generate.
- Press detect, pending/overrun logic and the FSM stay in the top module.

Test Plan (bench uses DEBOUNCE_CYCLES=4, NUM_BTNS=5):
- Glitch: btn_in[2] high for 3 cycles then low -> btn_level stays 0 and evt_valid never asserts.
- Single press with evt_ready=1:
  - btn_in[2] held high for 10 cycles -> btn_level[2] rises 6 cycles after the input change.
  - evt_valid pulses for 1 cycle with evt_id=2, 3 cycles after btn_level rises.
  - Release and re-press gives exactly one more event.
- Round-robin with evt_ready=1: buttons 0, 3 and 4 debounced in the same cycle -> events issued in order 0, 3, 4. A further simultaneous press of buttons 0 and 4 then yields 0 and 4 in that order (last_grant=4 wraps to 0).
- Backpressure: evt_ready=0 while buttons 1 and 2 are pending -> evt_id=1 is held stable for 20 cycles. Raising evt_ready then gives id 1, followed by id 2 two cycles later.
- Overrun with evt_ready=0:
  - Press, release and re-press button 3 -> overrun[3]=1 and only one event with id 3 is issued.
  - Pulsing clr_overrun -> overrun=0.
- Reset mid-operation: assert rst while evt_valid=1 (id 1) -> the next cycle has evt_valid=0 and pending=0. The first event after reset with buttons 0 and 1 pressed has evt_id=0.

Source files
------------

// File: rtl/btn_sched_pkg.sv
// btn_sched_pkg: shared types, constants and the round-robin arbiter function
package btn_sched_pkg;

    typedef enum logic {IDLE, OFFER} sched_state_t;

    localparam int SYNC_STAGES = 2;
    localparam int MAX_BTNS = 16;

    // Scans last_grant+num down to last_grant+1 so the nearest set bit after last_grant is written last
    function automatic int rr_next(logic [MAX_BTNS-1:0] pending, int last_grant, int num);
        int idx;
        int win;
        win = 0;
        for (int k = num; k >= 1; k--) begin
            idx = last_grant + k;
            if (idx >= num) idx -= num;
            if (pending[idx]) win = idx;
        end
        return win;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: two-flop synchronizer and stable-count debounce for a single button
module button_debouncer
    import btn_sched_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0] cnt;
    logic sync;

    assign sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            cnt <= '0;
            level <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
            if (sync == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/button_event_scheduler.sv
// button_event_scheduler: debounces buttons, turns presses into pending events and
// offers them round-robin on a single valid/ready channel.
module button_event_scheduler
    import btn_sched_pkg::*;
#(
    parameter int NUM_BTNS = 5,
    parameter int DEBOUNCE_CYCLES = 100000,
    localparam int ID_W = $clog2(NUM_BTNS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BTNS-1:0] btn_in,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [ID_W-1:0]     evt_id,
    output logic [NUM_BTNS-1:0] btn_level,
    output logic [NUM_BTNS-1:0] overrun,
    input  logic                clr_overrun
);

    sched_state_t state, state_n;
    logic [NUM_BTNS-1:0] level_d, press, pending, accept_vec;
    logic [ID_W-1:0] last_grant, id_n, grant_n;
    logic valid_n, accept;

    for (genvar g = 0; g < NUM_BTNS; g++) begin : g_deb
        button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk  (clk),
            .rst  (rst),
            .raw  (btn_in[g]),
            .level(btn_level[g])
        );
    end

    assign accept = (state == OFFER) && evt_ready;
    assign accept_vec = accept ? NUM_BTNS'(1) << evt_id : '0;

    // A press landing on the accepted button re-arms it, so it is neither lost nor an overrun
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            evt_valid <= 1'b0;
            evt_id <= '0;
            last_grant <= ID_W'(NUM_BTNS - 1);
            level_d <= '0;
            press <= '0;
            pending <= '0;
            overrun <= '0;
        end else begin
            state <= state_n;
            evt_valid <= valid_n;
            evt_id <= id_n;
            last_grant <= grant_n;
            level_d <= btn_level;
            press <= btn_level & ~level_d;
            pending <= press | (pending & ~accept_vec);
            overrun <= (clr_overrun ? '0 : overrun) | (press & pending & ~accept_vec);
        end
    end

    always_comb begin
        state_n = state;
        valid_n = evt_valid;
        id_n = evt_id;
        grant_n = last_grant;
        if (state == IDLE) begin
            if (|pending) begin
                state_n = OFFER;
                valid_n = 1'b1;
                id_n = ID_W'(rr_next(MAX_BTNS'(pending), int'(last_grant), NUM_BTNS));
            end
        end else if (evt_ready) begin
            state_n = IDLE;
            valid_n = 1'b0;
            grant_n = evt_id;
        end
    end

endmodule

// File: tb/tb_button_event_scheduler.sv
// tb_button_event_scheduler: directed stimulus with an event-id scoreboard popped by a handshake monitor
module tb_button_event_scheduler;

    localparam int NB = 5;
    localparam int DC = 4;

    logic clk = 1'b0;
    logic rst;
    logic [NB-1:0] btn_in;
    logic evt_valid;
    logic evt_ready;
    logic [2:0] evt_id;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] overrun;
    logic clr_overrun;

    int cmp = 0;
    int bad = 0;
    int n_acc = 0;
    int exp_q[$];

    button_event_scheduler #(.NUM_BTNS(NB), .DEBOUNCE_CYCLES(DC)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_in     (btn_in),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_id     (evt_id),
        .btn_level  (btn_level),
        .overrun    (overrun),
        .clr_overrun(clr_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, int act, int exp);
        cmp++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && evt_valid && evt_ready) begin
            n_acc++;
            if (exp_q.size() == 0) begin
                cmp++;
                bad++;
                $display("FAIL unexpected_event: got id %0d with empty scoreboard", evt_id);
            end else begin
                chk("evt_id", int'(evt_id), exp_q.pop_front());
            end
        end
    end

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(string name);
        int n = 0;
        while (!evt_valid && n < 30) begin
            cyc(1);
            n++;
        end
        chk(name, int'(evt_valid), 1);
    endtask

    initial begin
        int base, n;
        bit seen;
        rst = 1'b1;
        btn_in = '0;
        evt_ready = 1'b1;
        clr_overrun = 1'b0;
        cyc(3);
        chk("rst_valid", int'(evt_valid), 0);
        chk("rst_id", int'(evt_id), 0);
        chk("rst_level", int'(btn_level), 0);
        chk("rst_overrun", int'(overrun), 0);
        rst = 1'b0;
        cyc(1);

        // glitch of 3 cycles on button 2
        btn_in[2] = 1'b1;
        cyc(3);
        btn_in[2] = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            if (btn_level != 0 || evt_valid) seen = 1;
        end
        chk("glitch_ignored", int'(seen), 0);

        // round-robin: 0,3,4 then 0,4 with wrap
        base = n_acc;
        exp_q.push_back(0); exp_q.push_back(3); exp_q.push_back(4);
        btn_in = 5'b11001;
        cyc(20);
        chk("rr_count1", n_acc - base, 3);
        btn_in = '0;
        cyc(10);
        base = n_acc;
        exp_q.push_back(0); exp_q.push_back(4);
        btn_in = 5'b10001;
        cyc(20);
        chk("rr_count2", n_acc - base, 2);
        btn_in = '0;
        cyc(10);

        // single press latency on button 2
        base = n_acc;
        exp_q.push_back(2);
        btn_in[2] = 1'b1;
        n = 0;
        while (!btn_level[2] && n < 20) begin
            cyc(1);
            n++;
        end
        chk("level_latency", n, 6);
        n = 0;
        while (!evt_valid && n < 20) begin
            cyc(1);
            n++;
        end
        chk("valid_latency", n, 3);
        chk("single_id", int'(evt_id), 2);
        cyc(1);
        chk("valid_one_cycle", int'(evt_valid), 0);
        cyc(6);
        btn_in[2] = 1'b0;
        cyc(10);
        chk("single_count", n_acc - base, 1);
        base = n_acc;
        exp_q.push_back(2);
        btn_in[2] = 1'b1;
        cyc(14);
        chk("repress_count", n_acc - base, 1);
        btn_in[2] = 1'b0;
        cyc(10);

        // backpressure with buttons 1 and 2 pending
        evt_ready = 1'b0;
        exp_q.push_back(1); exp_q.push_back(2);
        btn_in = 5'b00110;
        wait_valid("bp_valid");
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (!evt_valid || evt_id != 3'd1) seen = 1;
            cyc(1);
        end
        chk("bp_stable", int'(seen), 0);
        evt_ready = 1'b1;
        cyc(1);
        chk("bp_gap", int'(evt_valid), 0);
        cyc(1);
        chk("bp_second_valid", int'(evt_valid), 1);
        chk("bp_second_id", int'(evt_id), 2);
        btn_in = '0;
        cyc(12);

        // overrun on button 3
        evt_ready = 1'b0;
        base = n_acc;
        exp_q.push_back(3);
        btn_in[3] = 1'b1;
        cyc(12);
        btn_in[3] = 1'b0;
        cyc(10);
        btn_in[3] = 1'b1;
        cyc(12);
        chk("overrun_set", int'(overrun), 8);
        evt_ready = 1'b1;
        cyc(10);
        chk("overrun_one_event", n_acc - base, 1);
        chk("overrun_sticky", int'(overrun), 8);
        clr_overrun = 1'b1;
        cyc(1);
        clr_overrun = 1'b0;
        chk("overrun_clear", int'(overrun), 0);
        btn_in[3] = 1'b0;
        cyc(10);

        // reset in the middle of an offer
        evt_ready = 1'b0;
        btn_in[1] = 1'b1;
        wait_valid("rst_mid_valid");
        chk("rst_mid_id", int'(evt_id), 1);
        btn_in = '0;
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("rst_mid_valid_clr", int'(evt_valid), 0);
        chk("rst_mid_pending_clr", int'(dut.pending), 0);
        base = n_acc;
        evt_ready = 1'b1;
        exp_q.push_back(0); exp_q.push_back(1);
        btn_in = 5'b00011;
        cyc(20);
        chk("post_rst_count", n_acc - base, 2);
        btn_in = '0;
        cyc(10);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end

endmodule
